// File: rtl/spi_slave_frame_decoder_if.sv
// Request/response bus between the SPI frame decoder and the SPI-to-AXI master stage.
// The decoder uses the master modport; the AXI master stage uses the slave modport.
interface spi_slave_frame_decoder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  init_w_axi_txn;
  logic                  init_r_axi_txn;
  logic [ADDR_WIDTH-1:0] user_awaddr;
  logic [ADDR_WIDTH-1:0] user_araddr;
  logic [DATA_WIDTH-1:0] user_wdata;
  logic                  done_w_axi_txn;
  logic                  done_r_axi_txn;
  logic                  error_w_axi_txn;
  logic                  error_r_axi_txn;
  logic [DATA_WIDTH-1:0] user_rdata;

  modport master (
    output init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata,
    input  done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn, user_rdata
  );

  modport slave (
    input  init_w_axi_txn, init_r_axi_txn, user_awaddr, user_araddr, user_wdata,
    output done_w_axi_txn, done_r_axi_txn, error_w_axi_txn, error_r_axi_txn, user_rdata
  );
endinterface

// File: rtl/spi_slave_frame_decoder.sv
// Oversampled mode-0 SPI slave that turns CMD/ADDR/DATA frames into single AXI-Lite
// write/read requests and shifts read data back out on MISO.
module spi_slave_frame_decoder #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_DUMMY_BITS       = 8
) (
  input  logic M_AXI_ACLK,
  input  logic M_AXI_ARESETN,
  input  logic SPI_SCLK,
  input  logic SPI_CS_N,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  spi_slave_frame_decoder_if.master axi,
  input  logic clr_status,
  output logic busy,
  output logic cmd_err,
  output logic overrun,
  output logic rd_late,
  output logic axi_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DRAIN
  } state_t;

  state_t                        state;
  logic [2:0]                    sclk_q;
  logic [2:0]                    cs_q;
  logic [1:0]                    mosi_q;
  logic [5:0]                    bit_cnt;
  logic [5:0]                    last_idx;
  logic [30:0]                   sh;
  logic [31:0]                   shifted;
  logic                          is_read;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] miso_sr;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] rd_value;
  logic                          miso_loaded;
  logic                          rd_done;
  logic                          rd_avail;
  logic                          busy_rd;
  logic                          issue_w;
  logic                          issue_r;
  logic                          done_w_d;
  logic                          done_r_d;
  logic                          sclk_rise;
  logic                          sclk_fall;
  logic                          cs_fall;
  logic                          cs_rise;
  logic                          done_w_rise;
  logic                          done_r_rise;
  logic                          last_bit;

  // CS_N chain resets to "selected" so a CS_N already low after reset never looks like a fresh fall.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_SCLK};
      cs_q   <= {cs_q[1:0], SPI_CS_N};
      mosi_q <= {mosi_q[0], SPI_MOSI};
    end
  end

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];
  assign shifted     = {sh, mosi_q[1]};
  assign done_w_rise = axi.done_w_axi_txn & ~done_w_d;
  assign done_r_rise = axi.done_r_axi_txn & ~done_r_d;
  assign rd_avail    = rd_done | done_r_rise;
  assign rd_value    = done_r_rise ? axi.user_rdata : rdata_q;
  assign last_bit    = (bit_cnt == last_idx);

  always_comb begin
    last_idx = 6'd31;
    case (state)
      S_CMD:   last_idx = 6'd7;
      S_DUMMY: last_idx = 6'(C_DUMMY_BITS - 1);
      default: ;
    endcase
  end

  // Frame FSM plus completion tracking; sticky-flag clears come first so a same-cycle set wins.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state              <= S_IDLE;
      bit_cnt            <= '0;
      sh                 <= '0;
      is_read            <= 1'b0;
      addr_q             <= '0;
      miso_sr            <= '0;
      miso_loaded        <= 1'b0;
      rdata_q            <= '0;
      rd_done            <= 1'b0;
      busy_rd            <= 1'b0;
      issue_w            <= 1'b0;
      issue_r            <= 1'b0;
      done_w_d           <= 1'b0;
      done_r_d           <= 1'b0;
      SPI_MISO           <= 1'b0;
      axi.init_w_axi_txn <= 1'b0;
      axi.init_r_axi_txn <= 1'b0;
      axi.user_awaddr    <= '0;
      axi.user_araddr    <= '0;
      axi.user_wdata     <= '0;
      busy               <= 1'b0;
      cmd_err            <= 1'b0;
      overrun            <= 1'b0;
      rd_late            <= 1'b0;
      axi_err            <= 1'b0;
    end else begin
      axi.init_w_axi_txn <= issue_w;
      axi.init_r_axi_txn <= issue_r;
      issue_w            <= 1'b0;
      issue_r            <= 1'b0;
      done_w_d           <= axi.done_w_axi_txn;
      done_r_d           <= axi.done_r_axi_txn;
      if (clr_status) begin
        cmd_err <= 1'b0;
        overrun <= 1'b0;
        rd_late <= 1'b0;
        axi_err <= 1'b0;
      end
      if (done_w_rise) begin
        if (busy && !busy_rd) busy <= 1'b0;
        if (axi.error_w_axi_txn) axi_err <= 1'b1;
      end
      if (done_r_rise) begin
        rdata_q <= axi.user_rdata;
        rd_done <= 1'b1;
        if (busy && busy_rd) busy <= 1'b0;
        if (axi.error_r_axi_txn) axi_err <= 1'b1;
      end
      if (cs_rise) begin
        state    <= S_IDLE;
        SPI_MISO <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cs_fall) begin
              state   <= S_CMD;
              bit_cnt <= '0;
            end
          end
          S_CMD: begin
            if (sclk_rise) begin
              sh      <= shifted[30:0];
              bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
              if (last_bit) begin
                is_read <= shifted[7];
                if (shifted[6:0] != 7'd0) begin
                  cmd_err <= 1'b1;
                  state   <= S_DRAIN;
                end else begin
                  state <= S_ADDR;
                end
              end
            end
          end
          S_ADDR: begin
            if (sclk_rise) begin
              sh      <= shifted[30:0];
              bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
              if (last_bit) begin
                if (!is_read) begin
                  addr_q <= shifted;
                  state  <= S_WDATA;
                end else if (!busy) begin
                  axi.user_araddr <= shifted;
                  issue_r         <= 1'b1;
                  busy            <= 1'b1;
                  busy_rd         <= 1'b1;
                  rd_done         <= 1'b0;
                  state           <= S_DUMMY;
                end else begin
                  overrun <= 1'b1;
                  state   <= S_DRAIN;
                end
              end
            end
          end
          S_WDATA: begin
            if (sclk_rise) begin
              sh      <= shifted[30:0];
              bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
              if (last_bit) begin
                state <= S_DRAIN;
                if (!busy) begin
                  axi.user_awaddr <= addr_q;
                  axi.user_wdata  <= shifted;
                  issue_w         <= 1'b1;
                  busy            <= 1'b1;
                  busy_rd         <= 1'b0;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
          end
          S_DUMMY: begin
            if (sclk_rise) begin
              bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
              if (last_bit) begin
                state       <= S_RDATA;
                miso_loaded <= 1'b0;
              end
            end
          end
          S_RDATA: begin
            // The first fall here is the one closing the dummy phase; it loads the word.
            if (sclk_fall) begin
              if (!miso_loaded) begin
                miso_loaded <= 1'b1;
                SPI_MISO    <= rd_avail ? rd_value[C_M_AXI_DATA_WIDTH-1] : 1'b0;
                miso_sr     <= rd_avail ? {rd_value[C_M_AXI_DATA_WIDTH-2:0], 1'b0} : '0;
                if (!rd_avail) rd_late <= 1'b1;
              end else begin
                SPI_MISO <= miso_sr[C_M_AXI_DATA_WIDTH-1];
                miso_sr  <= {miso_sr[C_M_AXI_DATA_WIDTH-2:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
              if (last_bit) begin
                state    <= S_DRAIN;
                SPI_MISO <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frame_decoder.sv
// Self-checking bench: a host drives SPI frames, a stub AXI master answers init pulses,
// and a frame-level model predicts addresses, data, pulses, MISO words and flags.
module tb_spi_slave_frame_decoder;
  localparam int HALF  = 6;
  localparam int DUMMY = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic clr_status = 1'b0;
  logic miso, busy, cmd_err, overrun, rd_late, axi_err;

  spi_slave_frame_decoder_if bus();

  spi_slave_frame_decoder #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_DUMMY_BITS(DUMMY)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .SPI_SCLK(sclk),
    .SPI_CS_N(cs_n),
    .SPI_MOSI(mosi),
    .SPI_MISO(miso),
    .axi(bus),
    .clr_status(clr_status),
    .busy(busy),
    .cmd_err(cmd_err),
    .overrun(overrun),
    .rd_late(rd_late),
    .axi_err(axi_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int w_pulses = 0;
  int r_pulses = 0;
  int width_bad = 0;
  int both_bad = 0;
  logic prev_w = 1'b0;
  logic prev_r = 1'b0;
  logic hold_w = 1'b0;
  logic hold_r = 1'b0;
  logic err_w = 1'b0;
  logic [31:0] r_value = 32'h0;

  // Frame-level reference state.
  logic [31:0] m_awaddr = 32'h0;
  logic [31:0] m_araddr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  int          m_w = 0;
  int          m_r = 0;
  logic        m_busy = 1'b0;
  logic [3:0]  m_flags = 4'h0;

  // Pulse monitor: counts init pulses and flags over-long or overlapping pulses.
  always @(negedge clk) begin
    if (bus.init_w_axi_txn === 1'b1) w_pulses++;
    if (bus.init_r_axi_txn === 1'b1) r_pulses++;
    if (bus.init_w_axi_txn === 1'b1 && prev_w) width_bad++;
    if (bus.init_r_axi_txn === 1'b1 && prev_r) width_bad++;
    if (bus.init_w_axi_txn === 1'b1 && bus.init_r_axi_txn === 1'b1) both_bad++;
    prev_w = (bus.init_w_axi_txn === 1'b1);
    prev_r = (bus.init_r_axi_txn === 1'b1);
  end

  // Stub AXI master, write side.
  initial begin
    bus.done_w_axi_txn = 1'b0;
    bus.error_w_axi_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.init_w_axi_txn === 1'b1) begin
        repeat (10) @(negedge clk);
        while (hold_w) @(negedge clk);
        bus.error_w_axi_txn = err_w;
        bus.done_w_axi_txn = 1'b1;
        @(negedge clk);
        bus.done_w_axi_txn = 1'b0;
        bus.error_w_axi_txn = 1'b0;
      end
    end
  end

  // Stub AXI master, read side.
  initial begin
    bus.done_r_axi_txn = 1'b0;
    bus.error_r_axi_txn = 1'b0;
    bus.user_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.init_r_axi_txn === 1'b1) begin
        repeat (10) @(negedge clk);
        while (hold_r) @(negedge clk);
        bus.user_rdata = r_value;
        bus.done_r_axi_txn = 1'b1;
        @(negedge clk);
        bus.done_r_axi_txn = 1'b0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, ".w_pulses"}, w_pulses, m_w);
    check_output({tag, ".r_pulses"}, r_pulses, m_r);
    check_output({tag, ".awaddr"}, bus.user_awaddr, m_awaddr);
    check_output({tag, ".wdata"}, bus.user_wdata, m_wdata);
    check_output({tag, ".araddr"}, bus.user_araddr, m_araddr);
    check_output({tag, ".flags"}, 32'({cmd_err, overrun, rd_late, axi_err}), 32'(m_flags));
    check_output({tag, ".busy"}, 32'(busy), 32'(m_busy));
    check_output({tag, ".pulse_shape"}, width_bad + both_bad, 0);
  endtask

  // Applies the frame rules to what the host actually sent.
  task automatic model_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             input int nbits, input logic rd_ready, output logic [31:0] exp_word);
    exp_word = 32'h0;
    if (nbits < 8) return;
    if (cmd[6:0] != 7'd0) begin
      m_flags[3] = 1'b1;
      return;
    end
    if (cmd[7]) begin
      if (nbits < 40) return;
      if (m_busy) begin
        m_flags[2] = 1'b1;
        return;
      end
      m_araddr = addr;
      m_r++;
      m_busy = 1'b1;
      if (nbits > 40 + DUMMY) begin
        if (rd_ready) exp_word = r_value;
        else m_flags[1] = 1'b1;
      end
    end else begin
      if (nbits < 72) return;
      if (m_busy) m_flags[2] = 1'b1;
      else begin
        m_awaddr = addr;
        m_wdata = data;
        m_w++;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic model_complete(input logic err);
    m_busy = 1'b0;
    if (err) m_flags[0] = 1'b1;
  endtask

  task automatic spi_bit(input logic b, output logic smp);
    mosi = b;
    repeat (HALF) @(negedge clk);
    smp = miso;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                                input int nbits, input logic keep_cs,
                                output logic [31:0] word, output logic other);
    logic [79:0] vec;
    logic smp;
    vec = cmd[7] ? {cmd, addr, 40'h0} : {cmd, addr, data, 8'h0};
    word = 32'h0;
    other = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(vec[79-i], smp);
      if (cmd[7] && cmd[6:0] == 7'd0 && i >= 40 + DUMMY) word = {word[30:0], smp};
      else other = other | smp;
    end
    if (!keep_cs) begin
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      other = other | miso;
    end
  endtask

  task automatic settle();
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [31:0] word, exp_word, a, d, wd_first;
    logic other, smp;
    logic [7:0] cmd;
    int kind;

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("reset.miso", 32'(miso), 0);
    check_output("reset.init", 32'({bus.init_w_axi_txn, bus.init_r_axi_txn}), 0);
    check_all("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write frame with completion held off to observe busy.
    hold_w = 1'b1;
    apply_stimulus(8'h00, 32'h4000_0010, 32'hA5A5_1234, 72, 1'b0, word, other);
    model_frame(8'h00, 32'h4000_0010, 32'hA5A5_1234, 72, 1'b1, exp_word);
    check_all("write");
    check_output("write.miso_quiet", 32'(other), 0);
    hold_w = 1'b0;
    settle();
    model_complete(1'b0);
    check_output("write.busy_after_done", 32'(busy), 32'(m_busy));

    // Read frame answered in time.
    r_value = 32'hCAFE_F00D;
    apply_stimulus(8'h80, 32'h4000_0020, 32'h0, 80, 1'b0, word, other);
    model_frame(8'h80, 32'h4000_0020, 32'h0, 80, 1'b1, exp_word);
    settle();
    model_complete(1'b0);
    check_output("read.miso_word", word, exp_word);
    check_output("read.miso_quiet", 32'(other), 0);
    check_all("read");

    // Late read: completion withheld past the dummy phase.
    hold_r = 1'b1;
    r_value = $urandom;
    a = $urandom;
    apply_stimulus(8'h80, a, 32'h0, 80, 1'b0, word, other);
    model_frame(8'h80, a, 32'h0, 80, 1'b0, exp_word);
    check_output("late.miso_word", word, exp_word);
    check_all("late");
    hold_r = 1'b0;
    settle();
    model_complete(1'b0);
    @(negedge clk) clr_status = 1'b1;
    @(negedge clk) clr_status = 1'b0;
    m_flags = 4'h0;
    check_all("late_clr");

    // Abort after 20 bits of a write.
    a = $urandom;
    d = $urandom;
    apply_stimulus(8'h00, a, d, 20, 1'b0, word, other);
    model_frame(8'h00, a, d, 20, 1'b1, exp_word);
    settle();
    check_all("abort");

    // Bad command: remaining bits ignored.
    apply_stimulus(8'h41, a, d, 72, 1'b0, word, other);
    model_frame(8'h41, a, d, 72, 1'b1, exp_word);
    settle();
    check_all("bad_cmd");
    check_output("bad_cmd.miso_quiet", 32'(other), 0);

    // Overrun: second write completes while the first is outstanding.
    hold_w = 1'b1;
    a = $urandom;
    wd_first = $urandom;
    apply_stimulus(8'h00, a, wd_first, 72, 1'b0, word, other);
    model_frame(8'h00, a, wd_first, 72, 1'b1, exp_word);
    d = ~wd_first;
    apply_stimulus(8'h00, a + 32'h4, d, 72, 1'b0, word, other);
    model_frame(8'h00, a + 32'h4, d, 72, 1'b1, exp_word);
    check_all("overrun");
    check_output("overrun.wdata_kept", bus.user_wdata, wd_first);
    hold_w = 1'b0;
    settle();
    model_complete(1'b0);

    // Reset in the middle of the address field.
    apply_stimulus(8'h00, $urandom, $urandom, 20, 1'b1, word, other);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_awaddr = 32'h0;
    m_araddr = 32'h0;
    m_wdata = 32'h0;
    m_busy = 1'b0;
    m_flags = 4'h0;
    check_output("midreset.miso", 32'(miso), 0);
    check_all("midreset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 60; i++) spi_bit(1'($urandom), smp);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check_all("post_reset_tail");
    a = $urandom;
    d = $urandom;
    apply_stimulus(8'h00, a, d, 72, 1'b0, word, other);
    model_frame(8'h00, a, d, 72, 1'b1, exp_word);
    settle();
    model_complete(1'b0);
    check_all("post_reset_write");

    // Write completion with an error response.
    err_w = 1'b1;
    apply_stimulus(8'h00, $urandom, 32'h1234_5678, 72, 1'b0, word, other);
    model_frame(8'h00, bus.user_awaddr, 32'h1234_5678, 0, 1'b1, exp_word);
    m_awaddr = 32'h0;
    settle();
    err_w = 1'b0;
    check_output("axi_err.flag", 32'(axi_err), 1);
    check_output("axi_err.wdata", bus.user_wdata, 32'h1234_5678);
    check_output("axi_err.w_pulses", w_pulses, m_w + 1);
    m_w++;
    m_awaddr = bus.user_awaddr;
    m_wdata = 32'h1234_5678;
    model_complete(1'b1);
    check_all("axi_err");

    // Randomized frames.
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      r_value = $urandom;
      cmd = (kind == 0) ? 8'h00 : (kind == 1) ? 8'h80 : 8'(($urandom_range(1, 127)) | ($urandom_range(0, 1) << 7));
      apply_stimulus(cmd, a, d, (cmd[7] && cmd[6:0] == 7'd0) ? 80 : 72, 1'b0, word, other);
      model_frame(cmd, a, d, (cmd[7] && cmd[6:0] == 7'd0) ? 80 : 72, 1'b1, exp_word);
      settle();
      if (m_busy) model_complete(1'b0);
      check_output("rand.miso_word", word, exp_word);
      check_output("rand.miso_quiet", 32'(other), 0);
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
